throttle_meter: RTL and testbench

//  Receive-side counterpart of the pushbutton throttle. Samples an incoming slow square

---
 rtl/throttle_meter_if.sv | 23 ++
 rtl/throttle_meter.sv | 147 ++++++++++++++
 tb/tb_throttle_meter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/throttle_meter_if.sv
// Bundle of the throttle meter's measured input and decoded outputs.
// The master side is the meter itself; the slave side drives slow_clk and observes the results.
interface throttle_meter_if #(
   parameter int CNT_W = 24
);
   logic             slow_clk;
   logic [2:0]       freq_num;
   logic             lvl_valid;
   logic             upd;
   logic [CNT_W-1:0] period;
   logic             stalled;
   logic             overspeed;

   modport master (
      input  slow_clk,
      output freq_num, lvl_valid, upd, period, stalled, overspeed
   );

   modport slave (
      output slow_clk,
      input  freq_num, lvl_valid, upd, period, stalled, overspeed
   );
endinterface

// File: rtl/throttle_meter.sv
// Measures the period of the slow throttle square wave and decodes it back to a level 0..5.
// Optional LEVEL_CONFIRM_EN: freq_num moves only after two matching measurements.
module throttle_meter #(
   parameter int P0    = 5_000_000,
   parameter int CNT_W = 24
) (
   input  logic            CLK_50,
   input  logic            reset_n,
   throttle_meter_if.master bus
);

   localparam int TIMEOUT = (3 * P0) / 2;
   localparam int OVR     = P0 / 8;
   // Decision thresholds sit halfway between adjacent nominal periods P0/(k+1).
   localparam int B0 = (P0 * 3) / 4;
   localparam int B1 = (P0 * 5) / 12;
   localparam int B2 = (P0 * 7) / 24;
   localparam int B3 = (P0 * 9) / 40;
   localparam int B4 = (P0 * 11) / 60;

   typedef enum logic [1:0] {IDLE, MEAS, STALL} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             slow_p0, slow_p1, slow_p2;
   logic             rise;
   logic [CNT_W-1:0] p_meas;
   logic [2:0]       lvl_new;

   logic [2:0]       freq_num;
   logic             lvl_valid;
   logic             upd;
   logic [CNT_W-1:0] period;
   logic             stalled;
   logic             overspeed;
`ifdef LEVEL_CONFIRM_EN
   logic [2:0]       cand;
   logic             cand_vld;
`endif

   function automatic logic [2:0] decode_lvl(input logic [CNT_W-1:0] p);
      logic [2:0] l;
      if      (p >= CNT_W'(B0)) l = 3'd0;
      else if (p >= CNT_W'(B1)) l = 3'd1;
      else if (p >= CNT_W'(B2)) l = 3'd2;
      else if (p >= CNT_W'(B3)) l = 3'd3;
      else if (p >= CNT_W'(B4)) l = 3'd4;
      else                      l = 3'd5;
      return l;
   endfunction

   // Edge detect after the two synchroniser flops
   assign rise    = slow_p1 & ~slow_p2;
   assign p_meas  = cnt + CNT_W'(1);
   assign lvl_new = decode_lvl(p_meas);

   always_ff @(posedge CLK_50) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         slow_p0   <= 1'b0;
         slow_p1   <= 1'b0;
         slow_p2   <= 1'b0;
         freq_num  <= 3'd0;
         lvl_valid <= 1'b0;
         upd       <= 1'b0;
         period    <= '0;
         stalled   <= 1'b0;
         overspeed <= 1'b0;
`ifdef LEVEL_CONFIRM_EN
         cand      <= 3'd0;
         cand_vld  <= 1'b0;
`endif
      end else begin
         slow_p0 <= bus.slow_clk;
         slow_p1 <= slow_p0;
         slow_p2 <= slow_p1;
         upd     <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  state <= MEAS;
                  cnt   <= '0;
               end
            end
            MEAS: begin
               // A rise on the timeout cycle still counts as a valid measurement
               if (rise) begin
                  cnt <= '0;
                  if (p_meas < CNT_W'(OVR)) begin
                     overspeed <= 1'b1;
`ifdef LEVEL_CONFIRM_EN
                     cand_vld  <= 1'b0;
`endif
                  end else begin
                     overspeed <= 1'b0;
                     period    <= p_meas;
                     upd       <= 1'b1;
                     lvl_valid <= 1'b1;
`ifdef LEVEL_CONFIRM_EN
                     if (!lvl_valid) begin
                        freq_num <= lvl_new;
                        cand_vld <= 1'b0;
                     end else if (lvl_new == freq_num) begin
                        cand_vld <= 1'b0;
                     end else if (cand_vld && (cand == lvl_new)) begin
                        freq_num <= lvl_new;
                        cand_vld <= 1'b0;
                     end else begin
                        cand     <= lvl_new;
                        cand_vld <= 1'b1;
                     end
`else
                     freq_num  <= lvl_new;
`endif
                  end
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  state     <= STALL;
                  stalled   <= 1'b1;
                  lvl_valid <= 1'b0;
`ifdef LEVEL_CONFIRM_EN
                  cand_vld  <= 1'b0;
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STALL: begin
               if (rise) begin
                  state   <= MEAS;
                  cnt     <= '0;
                  stalled <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.freq_num  = freq_num;
   assign bus.lvl_valid = lvl_valid;
   assign bus.upd       = upd;
   assign bus.period    = period;
   assign bus.stalled   = stalled;
   assign bus.overspeed = overspeed;

endmodule

// File: tb/tb_throttle_meter.sv
// Bench for throttle_meter: table of slow_clk periods with expected decode, scoreboard on upd,
// plus hand sequences for stall, reset mid-measurement and the timeout boundary.
module tb_throttle_meter;
   localparam int P0    = 1200;
   localparam int CNT_W = 12;
   localparam int HI    = 40;

   logic CLK_50 = 1'b0;
   logic reset_n;
   always #10 CLK_50 = ~CLK_50;

   throttle_meter_if #(.CNT_W(CNT_W)) mif();
   throttle_meter #(.P0(P0), .CNT_W(CNT_W)) dut (
      .CLK_50 (CLK_50),
      .reset_n(reset_n),
      .bus    (mif)
   );

   // cls: 0 = rise with no result, 1 = in-range, 2 = overspeed, 3 = stall during gap then no result
   typedef struct {
      int per;
      int cls;
      int lvl;
   } vec_t;
   typedef struct {
      int freq;
      int per;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   m_freq, m_per, m_cand;
   bit   m_lv, m_ovr, m_cv;
   logic prev_upd = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void add(input int p, input int c, input int l);
      vec_t v;
      v.per = p;
      v.cls = c;
      v.lvl = l;
      vecs.push_back(v);
   endfunction

   task automatic model_reset();
      m_freq = 0; m_per = 0; m_cand = 0;
      m_lv = 0; m_ovr = 0; m_cv = 0;
      sb.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_freq_num"},  int'(mif.freq_num),  0);
      chk({tag, "_lvl_valid"}, int'(mif.lvl_valid), 0);
      chk({tag, "_upd"},       int'(mif.upd),       0);
      chk({tag, "_period"},    int'(mif.period),    0);
      chk({tag, "_stalled"},   int'(mif.stalled),   0);
      chk({tag, "_overspeed"}, int'(mif.overspeed), 0);
   endtask

   task automatic step(input int gap, input int cls, input int lvl);
      exp_t e;
      mif.slow_clk = 1'b0;
      repeat (gap - HI) @(negedge CLK_50);
      mif.slow_clk = 1'b1;
      case (cls)
         1: begin
            m_ovr = 0;
            m_per = gap;
`ifdef LEVEL_CONFIRM_EN
            if (!m_lv) begin
               m_freq = lvl; m_cv = 0;
            end else if (lvl == m_freq) begin
               m_cv = 0;
            end else if (m_cv && m_cand == lvl) begin
               m_freq = lvl; m_cv = 0;
            end else begin
               m_cand = lvl; m_cv = 1;
            end
`else
            m_freq = lvl;
`endif
            m_lv = 1;
            e.freq = m_freq;
            e.per  = gap;
            sb.push_back(e);
         end
         2: begin
            m_ovr = 1;
            m_cv  = 0;
         end
         3: begin
            m_lv = 0;
            m_cv = 0;
         end
         default: ;
      endcase
      repeat (5) @(negedge CLK_50);
      chk("upd_pending", sb.size(), 0);
      chk("freq_num",  int'(mif.freq_num),  m_freq);
      chk("lvl_valid", int'(mif.lvl_valid), int'(m_lv));
      chk("overspeed", int'(mif.overspeed), int'(m_ovr));
      chk("stalled",   int'(mif.stalled),   0);
      chk("period",    int'(mif.period),    m_per);
      repeat (HI - 5) @(negedge CLK_50);
   endtask

   // Scoreboard: every upd pulse must match the oldest expected result
   always @(negedge CLK_50) begin
      if (mif.upd === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_upd: upd=1 with period=%0d but no result expected at %0t",
                     mif.period, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("upd_freq_num", int'(mif.freq_num), e.freq);
            chk("upd_period",   int'(mif.period),   e.per);
         end
         if (prev_upd === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL upd_width: upd high on two consecutive cycles at %0t", $time);
         end
      end
      prev_upd = mif.upd;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n      = 1'b0;
      mif.slow_clk = 1'b0;
      model_reset();
      repeat (3) @(negedge CLK_50);
      check_reset_vals("reset");
      reset_n = 1'b1;

      add(200, 0, 0);                                   // first rise only starts a measurement
      add(600, 1, 1); add(600, 1, 1); add(600, 1, 1);
      add(1200, 1, 0); add(400, 1, 2); add(300, 1, 3); add(240, 1, 4); add(200, 1, 5);
      add(900, 1, 0); add(899, 1, 1);
      add(500, 1, 1); add(499, 1, 2); add(350, 1, 2); add(349, 1, 3);
      add(270, 1, 3); add(269, 1, 4); add(220, 1, 4); add(219, 1, 5);
      add(150, 1, 5); add(149, 2, 0); add(100, 2, 0); add(240, 1, 4);
      add(1800, 1, 0);                                  // rise on the timeout cycle wins
      add(1801, 3, 0);                                  // one cycle later: stall first
      add(300, 1, 3);
      add(400, 1, 2); add(400, 1, 2);
      add(300, 1, 3); add(400, 1, 2); add(300, 1, 3); add(300, 1, 3);

      foreach (vecs[i]) step(vecs[i].per, vecs[i].cls, vecs[i].lvl);

      // Stall: slow_clk held low after a valid level
      mif.slow_clk = 1'b0;
      repeat (1795 - HI) @(negedge CLK_50);
      chk("pre_stall_stalled",   int'(mif.stalled),   0);
      chk("pre_stall_lvl_valid", int'(mif.lvl_valid), 1);
      repeat (15) @(negedge CLK_50);
      m_lv = 0;
      m_cv = 0;
      chk("stall_stalled",   int'(mif.stalled),   1);
      chk("stall_lvl_valid", int'(mif.lvl_valid), 0);
      chk("stall_freq_num",  int'(mif.freq_num),  m_freq);
      step(200, 0, 0);
      step(300, 1, 3);

      // Reset in the middle of a measurement
      mif.slow_clk = 1'b0;
      repeat (460) @(negedge CLK_50);
      reset_n = 1'b0;
      @(negedge CLK_50);
      check_reset_vals("midreset");
      reset_n = 1'b1;
      model_reset();
      step(300, 0, 0);
      step(300, 1, 3);

      repeat (10) @(negedge CLK_50);
      chk("final_sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
